// File: rtl/apb_req_master.sv
// APB requester: turns a valid/ready request port into APB SETUP/ACCESS transfers
// and returns one registered response (read data, slave error or timeout) per request.
module apb_req_master #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic          rsp_tmo,
  output logic [DW-1:0] rsp_rdata,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam int CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CLAST = CW'(TLAST);
  localparam logic [CW-1:0] CMAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
      rsp_rdata <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR     <= req_addr;
            PWRITE    <= req_write;
            PWDATA    <= req_wdata;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_tmo   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else if (TIMEOUT != 0 && wait_cnt == CLAST) begin
            // TIMEOUT-th consecutive wait cycle: give up on the slave
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_tmo   <= 1'b1;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else if (wait_cnt != CMAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: transfer-age model checked every cycle,
// plus literal per-transfer expectations.
module tb_apb_req_master;
  localparam int TMO = 4;

  logic       PCLK, PRESETn;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err, rsp_tmo;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  apb_req_master #(.AW(8), .DW(8), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo), .rsp_rdata(rsp_rdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b1;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: age 0 = idle, 1 = setup cycle, n>=2 = (n-1)-th access cycle.
  int         age;
  logic       m_rv, m_err, m_tmo, m_wr;
  logic [7:0] m_rd, m_addr, m_wd;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      age <= 0; m_rv <= 0; m_err <= 0; m_tmo <= 0; m_rd <= 0;
      m_wr <= 0; m_addr <= 0; m_wd <= 0;
    end else begin
      m_rv <= 1'b0;
      if (age == 0) begin
        if (req_valid) begin
          age <= 1; m_addr <= req_addr; m_wr <= req_write; m_wd <= req_wdata;
        end
      end else if (age == 1) begin
        age <= 2;
      end else if (PREADY) begin
        age <= 0; m_rv <= 1'b1; m_err <= PSLVERR; m_tmo <= 1'b0;
        m_rd <= m_wr ? 8'h00 : PRDATA;
      end else if (age - 1 == TMO) begin
        age <= 0; m_rv <= 1'b1; m_err <= 1'b1; m_tmo <= 1'b1; m_rd <= 8'h00;
      end else begin
        age <= age + 1;
      end
    end
  end

  always @(negedge PCLK) begin
    if (chk_en && PRESETn) begin
      check("psel",      PSEL,      age != 0);
      check("penable",   PENABLE,   age >= 2);
      check("req_ready", req_ready, age == 0);
      check("rsp_valid", rsp_valid, m_rv);
      check("rsp_err",   rsp_err,   m_err);
      check("rsp_tmo",   rsp_tmo,   m_tmo);
      check("rsp_rdata", rsp_rdata, m_rd);
      check("paddr",     PADDR,     m_addr);
      check("pwrite",    PWRITE,    m_wr);
      check("pwdata",    PWDATA,    m_wd);
    end
  end

  // One transfer; slave stalls `waits` ACCESS cycles then answers (unless aborted first).
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input int waits, input bit err, input logic [7:0] rd,
                      input int exp_en, input bit exp_err, input bit exp_tmo,
                      input logic [7:0] exp_rd);
    int en = 0;
    @(negedge PCLK);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
    PREADY = 1; PSLVERR = 1; PRDATA = 8'hEE;       // idle noise, must be ignored
    @(negedge PCLK);
    check("setup_psel", PSEL, 1);
    check("setup_pen",  PENABLE, 0);
    req_valid = 0; req_addr = 8'hFF; req_wdata = 8'hFF;
    @(negedge PCLK);
    check("acc_paddr",  PADDR, a);
    check("acc_pwrite", PWRITE, wr);
    check("acc_pwdata", PWDATA, d);
    for (int i = 0; i < 40; i++) begin
      if (!PENABLE) break;
      en++;
      PREADY = (i == waits); PSLVERR = (i == waits) && err;
      PRDATA = (i == waits) ? rd : 8'h5E;
      @(negedge PCLK);
    end
    PREADY = 0; PSLVERR = 0;
    check("xfer_done", PENABLE, 0);
    check("en_cycles", en, exp_en);
    check("rsp_pulse", rsp_valid, 1);
    check("rsp_err_l", rsp_err, exp_err);
    check("rsp_tmo_l", rsp_tmo, exp_tmo);
    check("rsp_rd_l",  rsp_rdata, exp_rd);
    check("idle_rdy",  req_ready, 1);
    @(negedge PCLK);
    check("rsp_1cyc",  rsp_valid, 0);
  endtask

  initial begin
    int st[$];
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    PRDATA = 0; PREADY = 0; PSLVERR = 0;
    PRESETn = 1;
    #5  PRESETn = 0;
    #7;
    check("rst_psel", PSEL, 0);
    check("rst_pen",  PENABLE, 0);
    check("rst_rv",   rsp_valid, 0);
    check("rst_rdy",  req_ready, 1);
    check("rst_paddr", PADDR, 0);
    #3  PRESETn = 1;
    chk_en = 1;

    xfer(1, 8'h03, 8'hA5, 0, 0, 8'h00, 1, 0, 0, 8'h00);  // plain write
    xfer(1, 8'h09, 8'h5A, 0, 1, 8'h00, 1, 1, 0, 8'h00);  // slave error
    xfer(0, 8'h05, 8'h00, 3, 0, 8'h3C, 4, 0, 0, 8'h3C);  // read, 3 waits (one short of timeout)
    xfer(0, 8'h07, 8'h00, 1, 1, 8'h77, 2, 1, 0, 8'h77);  // read with error
    xfer(0, 8'h0A, 8'h00, 99, 0, 8'h00, 4, 1, 1, 8'h00); // timeout after 4 waits
    xfer(1, 8'h0B, 8'hC3, 0, 0, 8'h00, 1, 0, 0, 8'h00);  // clean after timeout

    // back-to-back with req_valid held and zero-wait slave
    @(negedge PCLK);
    req_valid = 1; req_write = 1; req_addr = 8'h21; req_wdata = 8'h44; PREADY = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) st.push_back(cyc);
    end
    check("b2b_cnt", st.size() >= 3, 1);
    for (int i = 1; i < st.size(); i++) check("b2b_gap", st[i] - st[i-1], 3);

    // reset pulse during ACCESS
    for (int i = 0; i < 6; i++) begin
      if (PENABLE) break;
      @(negedge PCLK);
    end
    check("pre_kill_pen", PENABLE, 1);
    #2 PRESETn = 0;
    #1;
    check("kill_psel", PSEL, 0);
    check("kill_pen",  PENABLE, 0);
    check("kill_rdy",  req_ready, 1);
    req_valid = 0; PREADY = 0;
    @(negedge PCLK);
    PRESETn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("kill_norsp", rsp_valid, 0);
      check("kill_idle",  PSEL, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
